// File: rtl/mdu_pkg.sv
// Shared constants, opcode encodings and FSM state type for the multiply/divide unit.
package mdu_pkg;

  localparam int DATA_W = 32;
  localparam int ITERS  = 32;
  localparam int CNT_W  = $clog2(ITERS);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  // Two's-complement magnitude for signed ops; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x, input logic is_signed);
    return (is_signed && x[DATA_W-1]) ? (DATA_W'(0) - x) : x;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step; only built when MDU_DIV_EN is defined.
`ifdef MDU_DIV_EN
module mdu_div_step
  import mdu_pkg::*;
(
  input  logic [DATA_W:0]   rem_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);

  // rem_in is the shifted partial remainder, so it is always below 2*divisor and the result fits DATA_W bits.
  assign q_bit   = (rem_in >= {1'b0, divisor});
  assign rem_out = q_bit ? DATA_W'(rem_in - {1'b0, divisor}) : rem_in[DATA_W-1:0];

endmodule
`endif

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers, 34-cycle latency, Start ignored while Busy.
// Divide support (DIV/DIVU, DivByZero) is compiled in only when MDU_DIV_EN is defined.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              HI_We,
  input  logic              LO_We,
  input  logic [DATA_W-1:0] Wdata,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic              DivByZero
);

  state_e              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   b_reg;
  logic [2*DATA_W-1:0] p;
  logic                neg_q;
  logic                op_signed;
  logic                op_div;
  logic                accept;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_res;
  logic [DATA_W-1:0]   hi_res;
  logic [DATA_W-1:0]   lo_res;

`ifdef MDU_DIV_EN
  logic              is_div;
  logic              neg_r;
  logic [DATA_W-1:0] step_rem;
  logic              step_q;

  assign op_div = Op[1];
  assign accept = Start & ~Busy;

  mdu_div_step u_div_step (
    .rem_in  ({p[2*DATA_W-1:DATA_W], p[DATA_W-1]}),
    .divisor (b_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );
`else
  assign op_div = 1'b0;
  assign accept = Start & ~Busy & ~Op[1];
`endif

  assign op_signed = (Op == OP_MULT) | (Op == OP_DIV);
  assign Busy      = (state == CALC) | (state == FIX);
  assign Done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == CNT_W'(ITERS - 1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-add: p holds {partial product, remaining multiplier bits}.
  assign mul_sum = p[0] ? ({1'b0, p[2*DATA_W-1:DATA_W]} + {1'b0, b_reg})
                        : {1'b0, p[2*DATA_W-1:DATA_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      b_reg     <= '0;
      p         <= '0;
      neg_q     <= 1'b0;
      DivByZero <= 1'b0;
`ifdef MDU_DIV_EN
      is_div    <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else if (accept) begin
      cnt       <= '0;
      b_reg     <= abs_val(B, op_signed);
      p         <= {{DATA_W{1'b0}}, abs_val(A, op_signed)};
      neg_q     <= op_signed & (A[DATA_W-1] ^ B[DATA_W-1]);
      DivByZero <= op_div & (B == '0);
`ifdef MDU_DIV_EN
      is_div    <= op_div;
      neg_r     <= op_signed & A[DATA_W-1];
`endif
    end else if (state == CALC) begin
      cnt <= cnt + CNT_W'(1);
`ifdef MDU_DIV_EN
      // A zero divisor freezes p so the dividend magnitude survives to FIX.
      if (!is_div)         p <= {mul_sum, p[DATA_W-1:1]};
      else if (!DivByZero) p <= {step_rem, p[DATA_W-2:0], step_q};
`else
      p <= {mul_sum, p[DATA_W-1:1]};
`endif
    end
  end

  always_comb begin
    mul_res = neg_q ? ((2*DATA_W)'(0) - p) : p;
    hi_res  = mul_res[2*DATA_W-1:DATA_W];
    lo_res  = mul_res[DATA_W-1:0];
`ifdef MDU_DIV_EN
    if (is_div) begin
      if (DivByZero) begin
        hi_res = neg_r ? (DATA_W'(0) - p[DATA_W-1:0]) : p[DATA_W-1:0];
        lo_res = '1;
      end else begin
        hi_res = neg_r ? (DATA_W'(0) - p[2*DATA_W-1:DATA_W]) : p[2*DATA_W-1:DATA_W];
        lo_res = neg_q ? (DATA_W'(0) - p[DATA_W-1:0]) : p[DATA_W-1:0];
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HI <= '0;
      LO <= '0;
    end else if (state == FIX) begin
      HI <= hi_res;
      LO <= lo_res;
    end else if (!Busy) begin
      if (HI_We) HI <= Wdata;
      if (LO_We) LO <= Wdata;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  import mdu_pkg::*;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A, B;
  logic        HI_We, LO_We;
  logic [31:0] Wdata;
  logic        Busy, Done;
  logic [31:0] HI, LO;
  logic        DivByZero;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_dz = 1'b0;

  mult_div_unit dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .A(A), .B(B),
    .HI_We(HI_We), .LO_We(LO_We), .Wdata(Wdata),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO), .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns {DivByZero, HI, LO} from plain 64-bit arithmetic.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr, sp;
    longint unsigned ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT: begin
        sp = sa * sb;
        r  = sp;
      end
      OP_MULTU: r = ua * ub;
      OP_DIV: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        r  = {sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        r = ((ua % ub) << 32) | (ua / ub);
      end
    endcase
    return {1'b0, r};
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit wr);
    logic [31:0] wd;
    wd    = $urandom;
    Start = 1'b1; Op = op; A = a; B = b;
    HI_We = wr; LO_We = wr; Wdata = wd;
    tick();
    Start = 1'b0; HI_We = 1'b0; LO_We = 1'b0;
    Op = 2'($urandom); A = $urandom; B = $urandom; Wdata = $urandom;
    if (wr) begin
      chk("wr_at_start.hi", HI, wd);
      chk("wr_at_start.lo", LO, wd);
      exp_hi = wd;
      exp_lo = wd;
    end
    if (!op[1] || DIV_EN) {exp_dz, exp_hi, exp_lo} = model(op, a, b);
  endtask

  // Called one cycle after the accepting edge; returns in the Done cycle.
  task automatic wait_done(input string tag, input bit disturb);
    int cyc;
    bit busy_bad;
    cyc      = 1;
    busy_bad = 1'b0;
    while (Done !== 1'b1 && cyc < 60) begin
      if (Busy !== 1'b1) busy_bad = 1'b1;
      if (disturb && cyc == 5) begin
        Start = 1'b1; Op = 2'($urandom); A = $urandom; B = $urandom;
      end
      if (disturb && cyc == 6) begin
        Start = 1'b0; HI_We = 1'b1; LO_We = 1'b1; Wdata = $urandom;
      end
      if (disturb && cyc == 7) begin
        HI_We = 1'b0; LO_We = 1'b0;
      end
      tick();
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'd34);
    chk({tag, ".busy_run"}, 64'(busy_bad), 64'd0);
    chk({tag, ".busy_done"}, 64'(Busy), 64'd0);
    chk({tag, ".hi"}, HI, exp_hi);
    chk({tag, ".lo"}, LO, exp_lo);
    chk({tag, ".dz"}, 64'(DivByZero), 64'(exp_dz));
  endtask

  task automatic check_ignored(input string tag);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (Busy !== 1'b0 || Done !== 1'b0) bad = 1'b1;
      tick();
    end
    chk({tag, ".no_busy"}, 64'(bad), 64'd0);
    chk({tag, ".hi"}, HI, exp_hi);
    chk({tag, ".lo"}, LO, exp_lo);
    chk({tag, ".dz"}, 64'(DivByZero), 64'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    bit          seen;

    rst_n = 1'b0; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
    HI_We = 1'b0; LO_We = 1'b0; Wdata = '0;
    #3;
    chk("reset.busy", 64'(Busy), 64'd0);
    chk("reset.done", 64'(Done), 64'd0);
    chk("reset.hi", HI, 64'd0);
    chk("reset.lo", LO, 64'd0);
    chk("reset.dz", 64'(DivByZero), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    wd = 32'hA5A5_0001;
    HI_We = 1'b1; Wdata = wd;
    tick();
    HI_We = 1'b0;
    chk("mthi.hi", HI, wd);
    chk("mthi.lo", LO, 64'd0);
    LO_We = 1'b1; Wdata = 32'h0F0F_1234;
    tick();
    LO_We = 1'b0;
    chk("mtlo.lo", LO, 64'h0F0F_1234);
    chk("mtlo.hi", HI, wd);
    exp_hi = wd;
    exp_lo = 32'h0F0F_1234;

    start_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done("mult_m1x2", 1'b0);
    chk("mult_m1x2.hi_lit", HI, 64'hFFFF_FFFF);
    chk("mult_m1x2.lo_lit", LO, 64'hFFFF_FFFE);

    // Issued in the Done cycle: back-to-back.
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done("multu_max", 1'b0);
    chk("multu_max.hi_lit", HI, 64'hFFFF_FFFE);
    chk("multu_max.lo_lit", LO, 64'h0000_0001);
    tick();

`ifdef MDU_DIV_EN
    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done("div_neg", 1'b0);
    chk("div_neg.lo_lit", LO, 64'hFFFF_FFFD);
    chk("div_neg.hi_lit", HI, 64'hFFFF_FFFF);
    start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("div_ovf", 1'b0);
    chk("div_ovf.lo_lit", LO, 64'h8000_0000);
    chk("div_ovf.hi_lit", HI, 64'd0);
    start_op(OP_DIVU, 32'd100, 32'd0, 1'b0);
    wait_done("divu_by0", 1'b0);
    chk("divu_by0.dz_lit", 64'(DivByZero), 64'd1);
    chk("divu_by0.hi_lit", HI, 64'd100);
    start_op(OP_MULTU, 32'd3, 32'd5, 1'b0);
    wait_done("dz_clear", 1'b0);
    chk("dz_clear.dz_lit", 64'(DivByZero), 64'd0);
`else
    start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_ignored("div_off");
`endif

    start_op(OP_MULT, 32'h1234_5678, 32'h8765_4321, 1'b1);
    wait_done("disturbed", 1'b1);

    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom_range(1, 15);
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) tick();
      start_op(op, a, b, ($urandom_range(0, 3) == 0));
`ifdef MDU_DIV_EN
      wait_done("rand", ($urandom_range(0, 3) == 0));
`else
      if (op[1]) check_ignored("rand_div_off");
      else       wait_done("rand", ($urandom_range(0, 3) == 0));
`endif
    end

    tick();
    start_op(OP_MULT, 32'h0000_1234, 32'hFFFF_0000, 1'b0);
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        Start = 1'b1; Op = OP_MULTU; A = $urandom; B = $urandom;
      end
      if (c == 6) begin
        Start = 1'b0; HI_We = 1'b1; Wdata = 32'hDEAD_BEEF;
      end
      if (c == 7) HI_We = 1'b0;
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 64'(Busy), 64'd0);
    chk("abort.done", 64'(Done), 64'd0);
    chk("abort.hi", HI, 64'd0);
    chk("abort.lo", LO, 64'd0);
    chk("abort.dz", 64'(DivByZero), 64'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (Done !== 1'b0 || Busy !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("abort.no_done", 64'(seen), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    exp_dz = 1'b0;

    start_op(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    wait_done("after_abort", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Start  input  1  begin operation; sampled only when Busy=0.
REQ-005 Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
REQ-006 A  input  32  multiplicand/dividend; sampled with Start.
REQ-007 B  input  32  multiplier/divisor; sampled with Start.
REQ-008 HI_We  input  1  MTHI write strobe.
REQ-009 LO_We  input  1  MTLO write strobe.
REQ-010 Wdata  input  32  MTHI/MTLO write data.
REQ-011 Busy  output  1  operation in progress.
REQ-012 Done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-013 HI  output  32  high product / remainder register.
REQ-014 LO  output  32  low product / quotient register.
REQ-015 DivByZero  output  1  last accepted divide had B=0.

Function
REQ-016 FSM states: IDLE, CALC, FIX, DONE.
- IDLE/DONE + Start -> CALC; counter cleared.
- CALC runs 32 iterations, one per cycle, then -> FIX.
- FIX: sign correction; HI/LO written on exit -> DONE.
- DONE -> IDLE unless Start.
REQ-017 Timing from the edge that accepts Start (edge 0):
- Busy=1 after edges 0..32 (CALC and FIX).
- HI/LO updated at edge 33; Done=1 for the cycle following edge 33.
- Total latency 34 cycles.
REQ-018 Start while Busy=1 SHALL be ignored with no effect on the running operation; Start in DONE is accepted (back-to-back).
REQ-019 Operand handling:
- Signed ops (MULT, DIV) use magnitudes during CALC.
- MULT product negated when sign(A)!=sign(B).
- DIV quotient negated when signs differ; remainder takes sign of A.
- Unsigned ops use raw operands.
REQ-020 Multiply: iterative shift-add; 64-bit result, HI=[63:32], LO=[31:0].
REQ-021 Divide: restoring, one quotient bit per cycle; LO=quotient, HI=remainder.
REQ-022 B=0 divide: same 34-cycle latency; HI=A, LO=32'hFFFFFFFF; DivByZero=1.
REQ-023 DivByZero holds until the next accepted Start, where it is recomputed; it is 0 for multiplies.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0 with no trap.
REQ-025 HI_We/LO_We SHALL write Wdata on the next edge only when Busy=0; they are ignored while Busy=1.
REQ-026 HI_We/LO_We coinciding with an accepted Start SHALL apply the write; the result overwrites it at edge 33.
REQ-027 Done SHALL never assert without a preceding accepted Start.

Reset
REQ-028 rst_n low at any time, including mid-CALC, SHALL force IDLE, Busy=0, Done=0, DivByZero=0, HI=0, LO=0, counter=0.
REQ-029 No Done SHALL be generated for an operation aborted by reset.

Configuration
REQ-030 Macro MDU_DIV_EN:
- Defined: full divide support.
- Undefined: divide datapath removed; Start with Op[1]=1 ignored (no Busy, no Done, HI/LO unchanged); DivByZero tied 0; multiply behaviour and latency unchanged.

Structure
REQ-031 Package mdu_pkg SHALL hold:
- Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
- FSM state enum.
- Constants DATA_W=32 and ITERS=32.
REQ-032 One sub-module, mdu_div_step, SHALL be used: combinational single restoring-division step (remainder, divisor in; next remainder, quotient bit out), excluded when MDU_DIV_EN is undefined.

Verification
REQ-033 MULT A=0xFFFFFFFF, B=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE, Done exactly 34 cycles after Start.
REQ-034 MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-035 DIV A=0xFFFFFFF9, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 DIVU A=100, B=0 -> HI=100, LO=0xFFFFFFFF, DivByZero=1; next MULTU clears DivByZero.
REQ-037 MULT started, Start re-pulsed at cycle 5, HI_We at cycle 6, rst_n low at cycle 10:
- Busy=0, HI=LO=0 immediately.
- No Done.
- Re-pulsed Start and HI_We have no effect.
REQ-038 Back-to-back: Start in the Done cycle -> second Done exactly 34 cycles later. Without MDU_DIV_EN, DIV Start -> Busy stays 0.
